// File: rtl/net_tx_drain_if.sv
// Block-FIFO read side and PCS transmit side of the network TX drain.
// master = drain (pops FIFO, drives PCS), slave = FIFO/PCS environment.
interface net_tx_drain_if #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned CWIDTH = 2
);
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_d;
    logic [CWIDTH-1:0] fifo_c;
    logic              fifo_rd;
    logic              tx_ready;
    logic [DWIDTH-1:0] tx_d;
    logic [CWIDTH-1:0] tx_c;

    modport master (
        input  fifo_empty, fifo_d, fifo_c, tx_ready,
        output fifo_rd, tx_d, tx_c
    );

    modport slave (
        output fifo_empty, fifo_d, fifo_c, tx_ready,
        input  fifo_rd, tx_d, tx_c
    );
endinterface

// File: rtl/net_tx_drain.sv
// Pops 66b blocks from the network FIFO and forwards only whole frames to the PCS,
// filling gaps with idle blocks and aborting with an error block on underrun.
module net_tx_drain #(
    parameter int unsigned DWIDTH  = 64,
    parameter int unsigned CWIDTH  = 2,
    parameter int unsigned CNTW    = 16,
    parameter int unsigned MIN_IFG = 1
) (
    input  logic            clk,
    input  logic            reset,
    net_tx_drain_if.master  bus,
    output logic            busy,
    output logic [CNTW-1:0] frame_cnt,
    output logic [CNTW-1:0] drop_cnt,
    output logic [CNTW-1:0] underrun_cnt
);
    localparam int unsigned IfgW = (MIN_IFG > 0) ? $clog2(MIN_IFG + 1) : 1;
    localparam logic [CWIDTH-1:0] SyncCtrl = CWIDTH'(2'b01);
    localparam logic [DWIDTH-1:0] IdleBlk  = DWIDTH'(64'h000000000000001E);
    localparam logic [DWIDTH-1:0] ErrBlk   = DWIDTH'(64'h3C78F1E3C78F1E1E);

    typedef enum logic [1:0] {StIdle, StFrame, StDrain} state_e;

    state_e            state_q, state_d;
    logic [IfgW-1:0]   ifg_q, ifg_d, ifg_dec;
    logic [DWIDTH-1:0] txd_q, txd_d;
    logic [CWIDTH-1:0] txc_q, txc_d;
    logic              busy_q, busy_d;
    logic [CNTW-1:0]   frame_q, frame_d;
    logic [CNTW-1:0]   drop_q, drop_d;
    logic [CNTW-1:0]   under_q, under_d;
    logic              head_start, head_term, rd;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        head_start = !bus.fifo_empty && (bus.fifo_c == SyncCtrl) && (bus.fifo_d[7:0] == 8'h78);
        head_term  = !bus.fifo_empty && (bus.fifo_c == SyncCtrl) && (bus.fifo_d[7:0] > 8'h86);
        ifg_dec    = (ifg_q != '0) ? ifg_q - 1'b1 : ifg_q;
    end

    always_comb begin
        state_d = state_q;
        ifg_d   = ifg_q;
        txd_d   = txd_q;
        txc_d   = txc_q;
        frame_d = frame_q;
        drop_d  = drop_q;
        under_d = under_q;
        rd      = 1'b0;
        // Everything, including the pop, is frozen while the PCS stalls.
        if (bus.tx_ready && reset) begin
            unique case (state_q)
                StIdle: begin
                    txd_d = IdleBlk;
                    txc_d = SyncCtrl;
                    if (head_start && ifg_q == '0) begin
                        rd      = 1'b1;
                        txd_d   = bus.fifo_d;
                        txc_d   = bus.fifo_c;
                        state_d = StFrame;
                    end else begin
                        ifg_d = ifg_dec;
                        if (!bus.fifo_empty && !head_start) begin
                            rd     = 1'b1;
                            drop_d = sat_inc(drop_q);
                        end
                    end
                end
                StFrame: begin
                    if (!bus.fifo_empty) begin
                        rd    = 1'b1;
                        txd_d = bus.fifo_d;
                        txc_d = bus.fifo_c;
                        if (head_term) begin
                            frame_d = sat_inc(frame_q);
                            ifg_d   = IfgW'(MIN_IFG);
                            state_d = StIdle;
                        end
                    end else begin
                        txd_d   = ErrBlk;
                        txc_d   = SyncCtrl;
                        under_d = sat_inc(under_q);
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    txd_d = IdleBlk;
                    txc_d = SyncCtrl;
                    rd    = !bus.fifo_empty;
                    if (head_term) begin
                        ifg_d   = IfgW'(MIN_IFG);
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            ifg_q   <= '0;
            txd_q   <= IdleBlk;
            txc_q   <= SyncCtrl;
            busy_q  <= 1'b0;
            frame_q <= '0;
            drop_q  <= '0;
            under_q <= '0;
        end else begin
            state_q <= state_d;
            ifg_q   <= ifg_d;
            txd_q   <= txd_d;
            txc_q   <= txc_d;
            busy_q  <= busy_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
            under_q <= under_d;
        end
    end

    assign bus.fifo_rd  = rd;
    assign bus.tx_d     = txd_q;
    assign bus.tx_c     = txc_q;
    assign busy         = busy_q;
    assign frame_cnt    = frame_q;
    assign drop_cnt     = drop_q;
    assign underrun_cnt = under_q;
endmodule
